// File: rtl/axi2apb_apb_master.sv
// APB master engine: splits one bridge request into 32-bit APB beats
// and returns a single response (APB2/3/4, decode check, PREADY timeout).
module axi2apb_apb_master #(
    parameter int NUM_PSLAVE = 8,
    parameter int WIDTH_PAD  = 32,
    parameter int WIDTH_DAT  = 64,
    parameter int APB_MODE   = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                   PCLK,
    input  logic                   PRESET,
    output logic [NUM_PSLAVE-1:0]  PSEL,
    output logic                   PENABLE,
    output logic                   PWRITE,
    output logic [WIDTH_PAD-1:0]   PADDR,
    output logic [31:0]            PWDATA,
    output logic [3:0]             PSTRB,
    output logic [2:0]             PPROT,
    input  logic [31:0]            PRDATA,
    input  logic [NUM_PSLAVE-1:0]  PREADY,
    input  logic [NUM_PSLAVE-1:0]  PSLVERR,
    input  logic                   REQ_VALID,
    output logic                   REQ_READY,
    input  logic [WIDTH_PAD-1:0]   REQ_ADDR,
    input  logic                   REQ_WR,
    input  logic [WIDTH_DAT-1:0]   REQ_DATA,
    input  logic [WIDTH_DAT/8-1:0] REQ_BE,
    input  logic [2:0]             REQ_PROT,
    input  logic [NUM_PSLAVE-1:0]  REQ_SEL,
    output logic                   RSP_VALID,
    input  logic                   RSP_READY,
    output logic [WIDTH_DAT-1:0]   RSP_DATA,
    output logic [1:0]             RSP_ERROR
);

    localparam int BEATS = WIDTH_DAT / 32;
    localparam int BEW   = WIDTH_DAT / 8;
    localparam int KW    = $clog2(BEATS + 1);
    localparam int TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    state_t                state, state_d;
    logic [KW-1:0]         beat, beat_d;
    logic [TW-1:0]         cnt, cnt_d;
    logic [1:0]            err, err_d;

    logic [WIDTH_PAD-1:0]  addr_q;
    logic                  wr_q;
    logic [WIDTH_DAT-1:0]  data_q;
    logic [BEW-1:0]        be_q;
    logic [2:0]            prot_q;
    logic [NUM_PSLAVE-1:0] sel_q;
    logic [WIDTH_DAT-1:0]  rsp_q;

    logic                  rdy, slverr;
    logic [KW-1:0]         first, nxt;
    logic [3:0]            strb;

    // Lowest beat index >= from that needs an APB cycle; BEATS if none.
    function automatic logic [KW-1:0] find_beat(
        input logic           wr,
        input logic [BEW-1:0] be,
        input logic [KW-1:0]  from
    );
        find_beat = KW'(BEATS);
        for (int i = BEATS - 1; i >= 0; i--) begin
            if (KW'(i) >= from && (!wr || be[4*i +: 4] != 4'b0))
                find_beat = KW'(i);
        end
    endfunction

    assign rdy    = (APB_MODE == 2) ? 1'b1 : |(PREADY & sel_q);
    assign slverr = (APB_MODE >= 3) && |(PSLVERR & sel_q);
    assign first  = find_beat(REQ_WR, REQ_BE, '0);
    assign nxt    = find_beat(wr_q, be_q, beat + KW'(1));

    always_comb begin
        state_d = state;
        beat_d  = beat;
        cnt_d   = cnt;
        err_d   = err;
        unique case (state)
            IDLE: begin
                if (REQ_VALID) begin
                    beat_d = '0;
                    err_d  = 2'b00;
                    if (!$onehot(REQ_SEL)) begin
                        state_d = RESP;
                        err_d   = 2'b11;
                    end else if (first == KW'(BEATS)) begin
                        state_d = RESP;
                    end else begin
                        state_d = SETUP;
                        beat_d  = first;
                    end
                end
            end
            SETUP: begin
                state_d = ACCESS;
                cnt_d   = '0;
            end
            ACCESS: begin
                if (rdy) begin
                    if (slverr) begin
                        state_d = RESP;
                        err_d   = 2'b10;
                    end else if (nxt == KW'(BEATS)) begin
                        state_d = RESP;
                    end else begin
                        state_d = SETUP;
                        beat_d  = nxt;
                    end
                end else if (TIMEOUT != 0 && cnt == TW'(TIMEOUT - 1)) begin
                    // counter holds completed wait cycles; this one is the last allowed
                    state_d = RESP;
                    err_d   = 2'b11;
                end else begin
                    cnt_d = cnt + TW'(1);
                end
            end
            RESP: begin
                if (RSP_READY)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state <= IDLE;
            beat  <= '0;
            cnt   <= '0;
            err   <= 2'b00;
        end else begin
            state <= state_d;
            beat  <= beat_d;
            cnt   <= cnt_d;
            err   <= err_d;
        end
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            addr_q <= '0;
            wr_q   <= 1'b0;
            data_q <= '0;
            be_q   <= '0;
            prot_q <= 3'b0;
            sel_q  <= '0;
            rsp_q  <= '0;
        end else if (state == IDLE && REQ_VALID) begin
            addr_q <= REQ_ADDR;
            wr_q   <= REQ_WR;
            data_q <= REQ_DATA;
            be_q   <= REQ_BE;
            prot_q <= REQ_PROT;
            sel_q  <= REQ_SEL;
            rsp_q  <= '0;
        end else if (state == ACCESS && rdy && !wr_q) begin
            for (int i = 0; i < BEATS; i++) begin
                if (beat == KW'(i))
                    rsp_q[32*i +: 32] <= PRDATA;
            end
        end
    end

    always_comb begin
        PSEL    = '0;
        PENABLE = 1'b0;
        PWRITE  = 1'b0;
        PADDR   = '0;
        PWDATA  = 32'b0;
        PSTRB   = 4'b0;
        PPROT   = 3'b0;
        strb    = 4'b0;
        if (state == SETUP || state == ACCESS) begin
            PSEL    = sel_q;
            PENABLE = (state == ACCESS);
            PWRITE  = wr_q;
            PADDR   = {addr_q[WIDTH_PAD-1:2], 2'b00} + (WIDTH_PAD'(beat) << 2);
            for (int i = 0; i < BEATS; i++) begin
                if (beat == KW'(i)) begin
                    PWDATA = data_q[32*i +: 32];
                    strb   = be_q[4*i +: 4];
                end
            end
            if (APB_MODE == 4) begin
                PSTRB = wr_q ? strb : 4'b0;
                PPROT = prot_q;
            end
        end
    end

    assign REQ_READY = (state == IDLE) && !PRESET;
    assign RSP_VALID = (state == RESP);
    assign RSP_DATA  = rsp_q;
    assign RSP_ERROR = err;

endmodule

// File: tb/tb_axi2apb_apb_master.sv
// Randomized bench for axi2apb_apb_master: APB slave model plus a
// transaction-level reference of beats, response code, data and latency.
module tb_axi2apb_apb_master;

    localparam int NS = 8;
    localparam int TO = 4;

    logic          PCLK = 1'b0;
    logic          PRESET;
    logic [NS-1:0] PSEL;
    logic          PENABLE, PWRITE;
    logic [31:0]   PADDR, PWDATA, PRDATA;
    logic [3:0]    PSTRB;
    logic [2:0]    PPROT;
    logic [NS-1:0] PREADY, PSLVERR;
    logic          REQ_VALID, REQ_READY, REQ_WR;
    logic [31:0]   REQ_ADDR;
    logic [63:0]   REQ_DATA;
    logic [7:0]    REQ_BE;
    logic [2:0]    REQ_PROT;
    logic [NS-1:0] REQ_SEL;
    logic          RSP_VALID, RSP_READY;
    logic [63:0]   RSP_DATA;
    logic [1:0]    RSP_ERROR;

    int errors = 0;
    int checks = 0;

    axi2apb_apb_master #(
        .NUM_PSLAVE(NS), .WIDTH_PAD(32), .WIDTH_DAT(64),
        .APB_MODE(4), .TIMEOUT(TO)
    ) dut (
        .PCLK(PCLK), .PRESET(PRESET),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_ADDR(REQ_ADDR), .REQ_WR(REQ_WR), .REQ_DATA(REQ_DATA),
        .REQ_BE(REQ_BE), .REQ_PROT(REQ_PROT), .REQ_SEL(REQ_SEL),
        .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY),
        .RSP_DATA(RSP_DATA), .RSP_ERROR(RSP_ERROR)
    );

    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk(tag, {PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT,
                  RSP_VALID, RSP_DATA, RSP_ERROR}, '0);
    endtask

    task automatic txn(input logic [31:0] addr, input logic wr,
                       input logic [63:0] data, input logic [7:0] be,
                       input logic [2:0] prot, input logic [NS-1:0] sel,
                       input int waits, input int errbeat, input bit hang,
                       input logic [31:0] rd0, input logic [31:0] rd1,
                       input int hold);
        logic [31:0] ea[$];
        logic [31:0] ewd[$];
        logic [3:0]  es[$];
        logic [31:0] rdv[2];
        logic [31:0] base, diff;
        logic [3:0]  s;
        logic [1:0]  exp_code;
        logic [63:0] exp_rd;
        int          exp_cyc, cyc, rsp_cyc, nb, acc, cur_k;
        bit          got_rsp, ready;

        rdv[0] = rd0;
        rdv[1] = rd1;
        base   = addr & ~32'h3;

        // reference: which beats go out, when the response appears, what it carries
        exp_code = 2'b00;
        exp_rd   = '0;
        exp_cyc  = 1;
        if ($countones(sel) != 1) begin
            exp_code = 2'b11;
        end else begin
            for (int k = 0; k < 2; k++) begin
                s = be[4*k +: 4];
                if (wr && s == 4'h0) continue;
                ea.push_back(base + 32'(4 * k));
                ewd.push_back(data[32*k +: 32]);
                es.push_back(wr ? s : 4'h0);
                exp_cyc += 1;
                if (hang) begin
                    exp_cyc += TO;
                    exp_code = 2'b11;
                    break;
                end
                exp_cyc += waits + 1;
                if (!wr) exp_rd[32*k +: 32] = rdv[k];
                if (errbeat == k) begin
                    exp_code = 2'b10;
                    break;
                end
            end
        end

        @(negedge PCLK);
        chk("req_ready", REQ_READY, 1'b1);
        REQ_VALID = 1'b1;
        REQ_ADDR  = addr;
        REQ_WR    = wr;
        REQ_DATA  = data;
        REQ_BE    = be;
        REQ_PROT  = prot;
        REQ_SEL   = sel;
        RSP_READY = 1'b0;
        @(negedge PCLK);
        REQ_VALID = 1'b0;

        cyc = 1; rsp_cyc = 0; nb = 0; acc = 0; cur_k = 0; got_rsp = 0;
        while (!got_rsp && cyc < 100) begin
            if (RSP_VALID) begin
                got_rsp = 1;
                rsp_cyc = cyc;
            end else begin
                if (PSEL != 0 && !PENABLE) begin
                    if (nb < ea.size()) begin
                        chk("paddr", PADDR, ea[nb]);
                        if (wr) chk("pwdata", PWDATA, ewd[nb]);
                        chk("pstrb", PSTRB, es[nb]);
                    end else begin
                        chk("extra_beat", nb, ea.size());
                    end
                    chk("psel", PSEL, sel);
                    chk("pwrite", PWRITE, wr);
                    chk("pprot", PPROT, prot);
                    diff  = PADDR - base;
                    cur_k = int'(diff >> 2) & 1;
                    acc   = 0;
                    nb++;
                end
                PREADY  = NS'($urandom);
                PSLVERR = NS'($urandom);
                PRDATA  = $urandom;
                if (PSEL != 0 && PENABLE) begin
                    acc++;
                    ready   = !hang && (acc > waits);
                    PREADY  = (PREADY & ~sel) | (ready ? sel : '0);
                    PSLVERR = (PSLVERR & ~sel) |
                              ((ready && errbeat == cur_k) ? sel : '0);
                    if (ready) PRDATA = rdv[cur_k];
                end
                @(negedge PCLK);
                cyc++;
            end
        end
        PREADY  = '0;
        PSLVERR = '0;

        chk("rsp_seen", got_rsp, 1'b1);
        chk("rsp_cycle", rsp_cyc, exp_cyc);
        chk("beats", nb, ea.size());
        if (hang && ea.size() > 0) chk("timeout_acc", acc, TO);
        chk("rsp_error", RSP_ERROR, exp_code);
        chk("rsp_data", RSP_DATA, exp_rd);

        for (int h = 0; h < hold; h++) begin
            @(negedge PCLK);
            chk("hold_valid", RSP_VALID, 1'b1);
            chk("hold_data", {RSP_DATA, RSP_ERROR}, {exp_rd, exp_code});
            chk("hold_req_ready", REQ_READY, 1'b0);
        end
        RSP_READY = 1'b1;
        @(negedge PCLK);
        RSP_READY = 1'b0;
        chk("back_idle", {REQ_READY, RSP_VALID, PSEL}, {1'b1, 1'b0, NS'(0)});
    endtask

    initial begin
        logic [NS-1:0] rs;
        logic [7:0]    rbe;

        PRESET = 1'b1; PRDATA = '0; PREADY = '0; PSLVERR = '0;
        REQ_VALID = 1'b0; REQ_ADDR = '0; REQ_WR = 1'b0; REQ_DATA = '0;
        REQ_BE = '0; REQ_PROT = '0; REQ_SEL = '0; RSP_READY = 1'b0;
        repeat (3) @(negedge PCLK);
        chk_idle_outputs("reset_outputs");
        chk("reset_req_ready", REQ_READY, 1'b0);
        PRESET = 1'b0;
        @(negedge PCLK);
        chk("post_reset_req_ready", REQ_READY, 1'b1);

        // directed cases
        txn(32'h1000, 1, 64'h1111_2222_3333_4444, 8'hFF, 3'h5, 8'h04,
            0, -1, 0, 0, 0, 0);
        txn(32'h2004, 0, 0, 8'h00, 3'h2, 8'h10,
            3, -1, 0, 32'hA5A5A5A5, 32'h5A5A5A5A, 0);
        txn(32'h3000, 1, 64'hDEAD_BEEF_0BAD_F00D, 8'hF0, 3'h1, 8'h01,
            0, -1, 0, 0, 0, 0);
        txn(32'h3000, 1, 64'hDEAD_BEEF_0BAD_F00D, 8'h00, 3'h1, 8'h01,
            0, -1, 0, 0, 0, 0);
        txn(32'h3008, 1, 64'h0123_4567_89AB_CDEF, 8'h0C, 3'h0, 8'h80,
            1, -1, 0, 0, 0, 0);
        txn(32'h4000, 0, 0, 8'h00, 3'h0, 8'h00, 0, -1, 0, 1, 2, 0);
        txn(32'h4000, 1, 64'h5, 8'hFF, 3'h0, 8'h03, 0, -1, 0, 1, 2, 0);
        txn(32'h5000, 0, 0, 8'h00, 3'h0, 8'h02,
            0, 0, 0, 32'hCAFE0001, 32'hCAFE0002, 0);
        txn(32'h5000, 1, 64'h77, 8'hFF, 3'h0, 8'h02, 1, 1, 0, 0, 0, 0);
        txn(32'h6000, 0, 0, 8'h00, 3'h7, 8'h08, 0, -1, 1, 1, 2, 0);
        txn(32'hFFFF_FFFE, 0, 0, 8'h00, 3'h3, 8'h20,
            0, -1, 0, 32'h1234_5678, 32'h9ABC_DEF0, 0);
        txn(32'h1000, 1, 64'hFEED_FACE_0000_1111, 8'hFF, 3'h4, 8'h04,
            0, -1, 0, 0, 0, 5);

        // randomized traffic
        for (int n = 0; n < 40; n++) begin
            rs = NS'(1) << $urandom_range(NS - 1);
            if ($urandom_range(9) == 0) rs = NS'($urandom);
            rbe = 8'($urandom);
            if ($urandom_range(3) == 0) rbe = 8'hFF;
            txn($urandom, 1'($urandom), {$urandom, $urandom}, rbe,
                3'($urandom), rs, $urandom_range(3),
                ($urandom_range(5) == 0) ? int'($urandom_range(1)) : -1,
                ($urandom_range(7) == 0), $urandom, $urandom,
                $urandom_range(3));
        end

        // reset in the middle of an ACCESS phase
        @(negedge PCLK);
        REQ_VALID = 1'b1; REQ_ADDR = 32'h7000; REQ_WR = 1'b1;
        REQ_DATA = 64'hABCD; REQ_BE = 8'hFF; REQ_PROT = 3'h6;
        REQ_SEL = 8'h40;
        @(negedge PCLK);
        REQ_VALID = 1'b0;
        @(negedge PCLK);
        chk("pre_reset_access", {PENABLE, PSEL}, {1'b1, 8'h40});
        PRESET = 1'b1;
        @(negedge PCLK);
        chk_idle_outputs("mid_reset_outputs");
        chk("mid_reset_req_ready", REQ_READY, 1'b0);
        PRESET = 1'b0;
        repeat (3) @(negedge PCLK);
        chk("after_reset", {REQ_READY, RSP_VALID, PSEL}, {1'b1, 1'b0, NS'(0)});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
